// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC16 constants and the receive decoder state encoding.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // Reflected CRC16: residue is what the register holds after data plus its complemented CRC.
  localparam logic [15:0] CRC16_POLY    = 16'hA001;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RESP,
    ST_PID,
    ST_HSK,
    ST_DATA,
    ST_CHECK,
    ST_DRAIN
  } dec_state_e;

endpackage

// File: rtl/usb_packet_decode_if.sv
// UTMI receive bus plus RX FIFO write port seen by the packet decoder.
interface usb_packet_decode_if;
  logic       rx_active;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] rx_data;
  logic       fifo_full;
  logic [7:0] fifo_wdata;
  logic       fifo_write;

  modport master (
    output rx_active, rx_valid, rx_error, rx_data, fifo_full,
    input  fifo_wdata, fifo_write
  );

  modport slave (
    input  rx_active, rx_valid, rx_error, rx_data, fifo_full,
    output fifo_wdata, fifo_write
  );
endinterface

// File: rtl/usb_crc16_rx.sv
// Byte-wide CRC16 next-state function (reflected, LSB first); the caller holds the register.
module usb_crc16_rx
  import usb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC16_POLY;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_packet_decode.sv
// Host-side UTMI receive decoder: classifies handshake/DATA packets, checks PID, toggle
// and CRC16, and streams payload bytes (minus trailing CRC) into the RX FIFO.
module usb_packet_decode
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD  = 32,
  parameter int unsigned RESP_TIMEOUT = 96
) (
  input  logic                clk,
  input  logic                reset,
  usb_packet_decode_if.slave  utmi,
  input  logic                in_transfer,
  input  logic                hs_transfer,
  input  logic                expected_toggle,
  output logic                ack_received,
  output logic                nak_received,
  output logic                stall_received,
  output logic                data_done,
  output logic                ack_request,
  output logic [5:0]          rx_bytes,
  output logic                err_pid,
  output logic                err_crc,
  output logic                err_toggle,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam logic [7:0] MAX_P8 = 8'(MAX_PAYLOAD);
  localparam logic [7:0] TMO8   = 8'(RESP_TIMEOUT);

  dec_state_e  state_q, state_d;
  logic        kind_data_q, kind_data_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  pid_q, pid_d;
  logic [7:0]  dly0_q, dly0_d, dly1_q, dly1_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d, crc_nxt;
  logic        pulsed_q, pulsed_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        ack_q, ack_d, nak_q, nak_d, stall_q, stall_d;
  logic        done_q, done_d, areq_q, areq_d;
  logic [5:0]  rxb_q, rxb_d;
  logic        epid_q, epid_d, ecrc_q, ecrc_d, etog_q, etog_d;
  logic        eovf_q, eovf_d, etmo_q, etmo_d;
  logic [7:0]  tmo_inc, payload;
  logic        any_pulse;

  usb_crc16_rx u_crc (
    .crc_i  (crc_q),
    .data_i (utmi.rx_data),
    .crc_o  (crc_nxt)
  );

  assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
  assign payload = cnt_q - 8'd2;

  always_comb begin
    state_d     = state_q;
    kind_data_d = kind_data_q;
    tmo_d       = tmo_q;
    pid_d       = pid_q;
    dly0_d      = dly0_q;
    dly1_d      = dly1_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    rxb_d       = rxb_q;
    ack_d       = 1'b0;
    nak_d       = 1'b0;
    stall_d     = 1'b0;
    done_d      = 1'b0;
    areq_d      = 1'b0;
    epid_d      = 1'b0;
    ecrc_d      = 1'b0;
    etog_d      = 1'b0;
    eovf_d      = 1'b0;
    etmo_d      = 1'b0;

    if (state_q != ST_IDLE && utmi.rx_error) begin
      epid_d  = !pulsed_q;
      state_d = ST_DRAIN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (utmi.rx_active) begin
            state_d = ST_DRAIN;
          end else if (in_transfer || hs_transfer) begin
            state_d     = ST_WAIT_RESP;
            tmo_d       = '0;
            kind_data_d = in_transfer;
          end
        end
        ST_WAIT_RESP: begin
          if (utmi.rx_active) begin
            state_d = ST_PID;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO8) begin
              etmo_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_PID: begin
          if (utmi.rx_valid) begin
            pid_d = utmi.rx_data;
            cnt_d = '0;
            crc_d = CRC16_INIT;
            if (utmi.rx_data[7:4] != ~utmi.rx_data[3:0]) begin
              epid_d  = 1'b1;
              state_d = ST_DRAIN;
            end else if (!kind_data_q && (utmi.rx_data == PID_ACK ||
                         utmi.rx_data == PID_NAK || utmi.rx_data == PID_STALL)) begin
              state_d = ST_HSK;
            end else if (kind_data_q && (utmi.rx_data == PID_DATA0 ||
                         utmi.rx_data == PID_DATA1)) begin
              state_d = ST_DATA;
            end else begin
              epid_d  = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (!utmi.rx_active) begin
            epid_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_HSK: begin
          if (!utmi.rx_active) begin
            state_d = ST_IDLE;
            if (pid_q == PID_ACK)      ack_d   = 1'b1;
            else if (pid_q == PID_NAK) nak_d   = 1'b1;
            else                       stall_d = 1'b1;
          end else if (utmi.rx_valid) begin
            epid_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_DATA: begin
          // Verdict is registered on the falling rx_active edge; CHECK is a one-cycle settle.
          if (!utmi.rx_active) begin
            state_d = ST_CHECK;
            if (cnt_q < 8'd2 || crc_q != CRC16_RESIDUE) begin
              ecrc_d = 1'b1;
            end else if (pid_q[3] != expected_toggle) begin
              etog_d = 1'b1;
              areq_d = 1'b1;
            end else begin
              done_d = 1'b1;
              areq_d = 1'b1;
              rxb_d  = payload[5:0];
            end
          end else if (utmi.rx_valid) begin
            crc_d  = crc_nxt;
            dly0_d = utmi.rx_data;
            dly1_d = dly0_q;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            if (cnt_q >= 8'd2) begin
              if (payload >= MAX_P8 || utmi.fifo_full) begin
                eovf_d  = 1'b1;
                state_d = ST_DRAIN;
              end else begin
                write_d = 1'b1;
                wdata_d = dly1_q;
              end
            end
          end
        end
        ST_CHECK: state_d = ST_IDLE;
        ST_DRAIN: if (!utmi.rx_active) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    any_pulse = ack_d | nak_d | stall_d | done_d | areq_d | epid_d | ecrc_d |
                etog_d | eovf_d | etmo_d;
    pulsed_d  = (state_q == ST_IDLE) ? 1'b0 : (pulsed_q | any_pulse);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_data_q <= 1'b0;
      tmo_q       <= '0;
      pid_q       <= '0;
      dly0_q      <= '0;
      dly1_q      <= '0;
      cnt_q       <= '0;
      crc_q       <= CRC16_INIT;
      pulsed_q    <= 1'b0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rxb_q       <= '0;
      {ack_q, nak_q, stall_q, done_q, areq_q} <= '0;
      {epid_q, ecrc_q, etog_q, eovf_q, etmo_q} <= '0;
    end else begin
      state_q     <= state_d;
      kind_data_q <= kind_data_d;
      tmo_q       <= tmo_d;
      pid_q       <= pid_d;
      dly0_q      <= dly0_d;
      dly1_q      <= dly1_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      pulsed_q    <= pulsed_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rxb_q       <= rxb_d;
      {ack_q, nak_q, stall_q, done_q, areq_q} <= {ack_d, nak_d, stall_d, done_d, areq_d};
      {epid_q, ecrc_q, etog_q, eovf_q, etmo_q} <= {epid_d, ecrc_d, etog_d, eovf_d, etmo_d};
    end
  end

  assign utmi.fifo_wdata = wdata_q;
  assign utmi.fifo_write = write_q;
  assign ack_received    = ack_q;
  assign nak_received    = nak_q;
  assign stall_received  = stall_q;
  assign data_done       = done_q;
  assign ack_request     = areq_q;
  assign rx_bytes        = rxb_q;
  assign err_pid         = epid_q;
  assign err_crc         = ecrc_q;
  assign err_toggle      = etog_q;
  assign err_overflow    = eovf_q;
  assign err_timeout     = etmo_q;

endmodule

// File: tb/tb_usb_packet_decode.sv
// Directed bench for usb_packet_decode: handshakes, DATA packets, CRC/toggle/overflow/timeout errors.
module tb_usb_packet_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_transfer, hs_transfer, expected_toggle;
  logic       ack_received, nak_received, stall_received, data_done, ack_request;
  logic [5:0] rx_bytes;
  logic       err_pid, err_crc, err_toggle, err_overflow, err_timeout;

  usb_packet_decode_if bus ();

  usb_packet_decode #(.MAX_PAYLOAD(32), .RESP_TIMEOUT(96)) dut (
    .clk             (clk),
    .reset           (reset),
    .utmi            (bus),
    .in_transfer     (in_transfer),
    .hs_transfer     (hs_transfer),
    .expected_toggle (expected_toggle),
    .ack_received    (ack_received),
    .nak_received    (nak_received),
    .stall_received  (stall_received),
    .data_done       (data_done),
    .ack_request     (ack_request),
    .rx_bytes        (rx_bytes),
    .err_pid         (err_pid),
    .err_crc         (err_crc),
    .err_toggle      (err_toggle),
    .err_overflow    (err_overflow),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int c_ack, c_nak, c_stall, c_done, c_areq, c_epid, c_ecrc, c_etog, c_eovf, c_etmo;
  logic [7:0] wq[$];
  logic [7:0] pkt[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters: each nibble of the packed compare is one pulse count.
  always @(negedge clk) begin
    if (!reset) begin
      c_ack   += int'(ack_received);
      c_nak   += int'(nak_received);
      c_stall += int'(stall_received);
      c_done  += int'(data_done);
      c_areq  += int'(ack_request);
      c_epid  += int'(err_pid);
      c_ecrc  += int'(err_crc);
      c_etog  += int'(err_toggle);
      c_eovf  += int'(err_overflow);
      c_etmo  += int'(err_timeout);
      if (bus.fifo_write) wq.push_back(bus.fifo_wdata);
    end
  end

  task automatic clr();
    c_ack = 0; c_nak = 0; c_stall = 0; c_done = 0; c_areq = 0;
    c_epid = 0; c_ecrc = 0; c_etog = 0; c_eovf = 0; c_etmo = 0;
    wq.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected order: ack nak stall done ack_request err_pid err_crc err_toggle err_overflow err_timeout
  task automatic exp_pulses(input string tag, input logic [39:0] exp);
    chk({tag, "_pulses"},
        {4'(c_ack), 4'(c_nak), 4'(c_stall), 4'(c_done), 4'(c_areq),
         4'(c_epid), 4'(c_ecrc), 4'(c_etog), 4'(c_eovf), 4'(c_etmo)}, 64'(exp));
  endtask

  task automatic xfer(input logic is_in);
    step();
    in_transfer = is_in;
    hs_transfer = !is_in;
    step();
    in_transfer = 1'b0;
    hs_transfer = 1'b0;
  endtask

  task automatic send_pkt(input int full_at, input int err_at);
    step();
    bus.rx_active = 1'b1;
    step();
    foreach (pkt[i]) begin
      bus.fifo_full = (full_at >= 0 && i >= full_at);
      bus.rx_valid  = 1'b1;
      bus.rx_data   = pkt[i];
      bus.rx_error  = (i == err_at);
      step();
      bus.rx_valid  = 1'b0;
      bus.rx_error  = 1'b0;
      step();
    end
    bus.rx_active = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic settle();
    repeat (4) step();
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ d[k][b]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic build_data(input logic [7:0] pid, input int n, input logic [7:0] flip);
    logic [7:0]  body[$];
    logic [15:0] c;
    body.delete();
    for (int i = 0; i < n; i++) body.push_back(8'(i));
    c = ~crc16(body);
    pkt.delete();
    pkt.push_back(pid);
    foreach (body[i]) pkt.push_back(body[i]);
    pkt.push_back(c[7:0] ^ flip);
    pkt.push_back(c[15:8]);
  endtask

  task automatic chk_payload(input string tag, input int n);
    chk({tag, "_writes"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(wq[i]), 64'(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] hpid[3];
    logic [39:0] hexp[3];
    logic early;
    reset = 1'b1;
    in_transfer = 1'b0; hs_transfer = 1'b0; expected_toggle = 1'b0;
    bus.rx_active = 1'b0; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
    bus.rx_data = '0; bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({bus.fifo_wdata, bus.fifo_write, ack_received, nak_received, stall_received,
             data_done, ack_request, rx_bytes, err_pid, err_crc, err_toggle,
             err_overflow, err_timeout}), 64'(0));
    step();
    reset = 1'b0;
    clr();

    // Unsolicited packet is drained silently
    pkt = '{8'hD2};
    send_pkt(-1, -1);
    settle();
    exp_pulses("unsolicited", 40'h0);

    // Handshakes, with exact pulse timing for each
    hpid = '{8'hD2, 8'h5A, 8'h1E};
    hexp = '{40'h1000000000, 40'h0100000000, 40'h0010000000};
    for (int h = 0; h < 3; h++) begin
      clr();
      xfer(1'b0);
      pkt = '{hpid[h]};
      send_pkt(-1, -1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hsk%0d_timing", h),
          64'({ack_received, nak_received, stall_received}), 64'(hexp[h][39:36] << 2 |
          hexp[h][35:32] << 1 | hexp[h][31:28]));
      settle();
      exp_pulses($sformatf("hsk%0d", h), hexp[h]);
      chk($sformatf("hsk%0d_writes", h), 64'(wq.size()), 64'(0));
    end

    // Zero-length DATA0
    clr();
    expected_toggle = 1'b0;
    xfer(1'b1);
    pkt = '{8'hC3, 8'h00, 8'h00};
    send_pkt(-1, -1);
    settle();
    exp_pulses("zlp", 40'h0001100000);
    chk("zlp_rx_bytes", 64'(rx_bytes), 64'(0));
    chk("zlp_writes", 64'(wq.size()), 64'(0));

    // Maximum-length DATA1, correct CRC
    clr();
    expected_toggle = 1'b1;
    xfer(1'b1);
    build_data(8'h4B, 32, 8'h00);
    send_pkt(-1, -1);
    settle();
    exp_pulses("max", 40'h0001100000);
    chk("max_rx_bytes", 64'(rx_bytes), 64'(32));
    chk_payload("max", 32);

    // CRC bit flipped
    clr();
    xfer(1'b1);
    build_data(8'h4B, 32, 8'h04);
    send_pkt(-1, -1);
    settle();
    exp_pulses("badcrc", 40'h0000001000);
    chk("badcrc_rx_bytes", 64'(rx_bytes), 64'(32));

    // Toggle mismatch: duplicate, acknowledged but not counted
    clr();
    expected_toggle = 1'b0;
    xfer(1'b1);
    build_data(8'h4B, 5, 8'h00);
    send_pkt(-1, -1);
    settle();
    exp_pulses("toggle", 40'h0000100100);
    chk("toggle_rx_bytes", 64'(rx_bytes), 64'(32));

    // Bad PID check bits, rest of packet drained
    clr();
    xfer(1'b0);
    pkt = '{8'hC2, 8'hD2, 8'h11};
    send_pkt(-1, -1);
    settle();
    exp_pulses("badpid", 40'h0000010000);

    // FIFO full on the fourth due write
    clr();
    expected_toggle = 1'b1;
    xfer(1'b1);
    build_data(8'h4B, 10, 8'h00);
    send_pkt(6, -1);
    settle();
    exp_pulses("fifofull", 40'h0000000010);
    chk_payload("fifofull", 3);

    // One byte beyond MAX_PAYLOAD
    clr();
    xfer(1'b1);
    build_data(8'h4B, 33, 8'h00);
    send_pkt(-1, -1);
    settle();
    exp_pulses("toolong", 40'h0000000010);
    chk("toolong_writes", 64'(wq.size()), 64'(32));

    // rx_error mid payload
    clr();
    xfer(1'b1);
    build_data(8'h4B, 8, 8'h00);
    send_pkt(-1, 4);
    settle();
    exp_pulses("rxerr", 40'h0000010000);
    chk("rxerr_writes", 64'(wq.size()), 64'(1));

    // Response timeout: pulse lands exactly 96 clocks after in_transfer is sampled
    clr();
    step();
    in_transfer = 1'b1;
    step();
    in_transfer = 1'b0;
    early = 1'b0;
    @(negedge clk);
    early |= err_timeout;
    repeat (95) begin
      @(negedge clk);
      early |= err_timeout;
    end
    chk("tmo_early", 64'(early), 64'(0));
    @(negedge clk);
    chk("tmo_at_96", 64'(err_timeout), 64'(1));
    @(negedge clk);
    chk("tmo_after", 64'(err_timeout), 64'(0));
    settle();
    exp_pulses("tmo", 40'h0000000001);

    // Decoder must be back in IDLE and usable
    clr();
    xfer(1'b0);
    pkt = '{8'hD2};
    send_pkt(-1, -1);
    settle();
    exp_pulses("post_tmo", 40'h1000000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_packet_decode.md
# usb_packet_decode

Receive-side packet decoder for the USB host controller's UTMI path; the counterpart to the host packet encoder. Parses bytes arriving from the UTMI receiver into handshake and DATA0/DATA1 packets, validates PID check bits, data toggle and CRC16, and streams payload bytes into the host RX FIFO. Reports status pulses to the HC sequencer, including the `ack_request` that triggers the encoder's ACK transmission.

## Interface
- `MAX_PAYLOAD`, default 32: maximum data payload in bytes; longer packets are flagged as errors.
- `RESP_TIMEOUT`, default 96: number of clocks to wait for `rx_active` after `in_transfer` or `hs_transfer` before reporting a timeout.
- `clk`  in  1  single clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rx_active`  in  1  UTMI packet in progress.
- `rx_valid`  in  1  `rx_data` holds a valid byte this cycle.
- `rx_error`  in  1  UTMI receive error.
- `rx_data`  in  8  UTMI receive byte.
- `in_transfer`  in  1  pulse from the encoder: an IN token was sent, so a DATA packet is expected.
- `hs_transfer`  in  1  pulse from the encoder: an OUT/SETUP data stage was sent, so a handshake is expected.
- `expected_toggle`  in  1  expected DATA PID (0 = DATA0).
- `fifo_full`  in  1  RX FIFO cannot accept a write.
- `fifo_wdata`  out  8  payload byte to the RX FIFO.
- `fifo_write`  out  1  single-cycle FIFO write strobe.
- `ack_received`, `nak_received`, `stall_received`  out  1 each  handshake pulses.
- `data_done`  out  1  pulse: a valid DATA packet was received.
- `ack_request`  out  1  pulse to the encoder's `Ack` input.
- `rx_bytes`  out  6  payload byte count of the last DATA packet.
- `err_pid`, `err_crc`, `err_toggle`, `err_overflow`, `err_timeout`  out  1 each  error pulses.

## Operation
- States: IDLE, WAIT_RESP, PID, HSK, DATA, CHECK, DRAIN.
- IDLE: `in_transfer` or `hs_transfer` moves to WAIT_RESP, loads the timeout counter and latches the expected kind (data or handshake). An unsolicited `rx_active` goes to DRAIN.
- WAIT_RESP:
  - `rx_active` moves to PID.
  - If the counter reaches `RESP_TIMEOUT` first, pulse `err_timeout` and go to IDLE.
- PID: the first `rx_valid` byte is the PID.
  - If `rx_data[7:4] != ~rx_data[3:0]`, pulse `err_pid` and go to DRAIN.
  - If the expected kind is handshake and the PID is ACK (D2), NAK (5A) or STALL (1E), go to HSK.
  - If the expected kind is data and the PID is DATA0 (C3) or DATA1 (4B), go to DATA.
  - Any other PID: pulse `err_pid` and go to DRAIN.
- HSK:
  - A falling `rx_active` with no further byte: pulse the matching handshake output, then go to IDLE.
  - An extra byte: pulse `err_pid`, then go to DRAIN.
- DATA:
  - Each byte passes through a 2-byte delay line, so the trailing CRC bytes are never written to the FIFO.
  - A byte is written when a third byte pushes it out.
  - A running CRC16 covers every byte after the PID (reflected, polynomial 16'hA001, initial value 16'hFFFF, LSB first).
  - If the payload count would exceed `MAX_PAYLOAD`, or `fifo_full` is high when a write is due, pulse `err_overflow` and go to DRAIN.
- CHECK (entered when `rx_active` falls in DATA):
  - Fewer than 2 bytes after the PID: `err_crc`.
  - CRC residue != 16'hB001: `err_crc`.
  - PID toggle != `expected_toggle`: pulse `err_toggle` and `ack_request` (duplicate packet, acknowledged but not counted as new data). `data_done` stays low.
  - Otherwise: pulse `data_done` and `ack_request`, and latch `rx_bytes`.
- DRAIN: wait for `rx_active` low, then go to IDLE.
- `rx_error` in any state except IDLE: pulse `err_pid` (only if no error was already pulsed for this packet), then go to DRAIN.
- Bytes already written to the FIFO are not retracted on error; the sequencer flushes the FIFO.

## Timing
- All outputs are registered.
- Reset value of every output is 0: FIFO data, strobes and pulses, `rx_bytes`, and all error pulses.
- A FIFO write occurs on the clock after the `rx_valid` byte that pushes it out of the delay line.
- Status pulses (`ack_received`, `nak_received`, `stall_received`, `data_done`, `ack_request`, `err_crc`, `err_toggle`) assert exactly one cycle, on the cycle after `rx_active` is sampled low.
- Every pulse is one cycle wide, and at most one status/error pulse set fires per packet.
- The timeout counter is 8 bits and saturates; `err_timeout` asserts on the cycle the count equals `RESP_TIMEOUT`.
- `in_transfer`/`hs_transfer` outside IDLE are ignored.
- `reset` mid-packet returns to IDLE on the next edge and discards the delay line and CRC; the remainder of that packet is treated as unsolicited and drained.

## Structure
- Shared package `usb_pkg`:
  - PID constants (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL).
  - CRC16 polynomial and residue.
  - Decoder state enum.
- Sub-module `usb_crc16_rx`: byte-wide combinational CRC16 next-state function, registered in the parent; reusable for TX verification.

## Test plan
- `hs_transfer`, then a packet with byte D2 -> `ack_received` pulses once, no FIFO writes, state returns to IDLE.
- `in_transfer` with `expected_toggle`=0, then C3 00 00 (zero-length DATA0) -> `data_done` and `ack_request` pulse, `rx_bytes`=0, no FIFO write.
- `in_transfer`, DATA1 4B with 32 bytes 00..1F and correct CRC -> 32 FIFO writes 00..1F in order, `rx_bytes`=32, `data_done` pulses.
- Same packet with one CRC bit flipped -> `err_crc` pulses, no `ack_request`.
- Same packet but `expected_toggle`=0 -> `err_toggle` and `ack_request` pulse, `data_done` stays low.
- Error and timeout cases:
  - PID byte C2 -> `err_pid` pulses and the decoder drains.
  - `in_transfer` with no `rx_active` for 96 clocks -> `err_timeout` pulses on cycle 96.
  - `fifo_full` asserted mid-payload -> `err_overflow` pulses.
